bresenham_line_engine: RTL and testbench

//  All-octant Bresenham line rasteriser with a start handshake and a valid/ready pixel stream.

---
 rtl/bresenham_line_engine_if.sv | 29 ++
 rtl/bresenham_line_engine.sv | 174 +++++++++++++++++
 tb/tb_bresenham_line_engine.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bresenham_line_engine_if.sv
// Command and pixel-stream bundle for the Bresenham line engine.
// The master side issues draw commands and consumes pixels; the slave side is the engine.
interface bresenham_line_engine_if #(
  parameter int COORD_W = 10
);
  logic               start;
  logic [COORD_W-1:0] x0;
  logic [COORD_W-1:0] y0;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic               abort;
  logic               busy;
  logic               done;
  logic               pix_valid;
  logic               pix_ready;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               pix_last;

  modport master (
    output start, x0, y0, x1, y1, abort, pix_ready,
    input  busy, done, pix_valid, pix_x, pix_y, pix_last
  );

  modport slave (
    input  start, x0, y0, x1, y1, abort, pix_ready,
    output busy, done, pix_valid, pix_x, pix_y, pix_last
  );
endinterface

// File: rtl/bresenham_line_engine.sv
// All-octant Bresenham line rasteriser.
// IDLE latches the endpoints, SETUP derives the deltas/steps, DRAW presents one pixel per
// accepted beat, DONE pulses done for a single cycle before returning to IDLE.
module bresenham_line_engine #(
  parameter int COORD_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  bresenham_line_engine_if.slave  bus
);
  localparam int W = COORD_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [COORD_W-1:0]        cur_x_q, cur_x_d;
  logic [COORD_W-1:0]        cur_y_q, cur_y_d;
  logic [COORD_W-1:0]        end_x_q, end_x_d;
  logic [COORD_W-1:0]        end_y_q, end_y_d;
  logic signed [W-1:0]       dx_q, dx_d;
  logic signed [W-1:0]       dy_q, dy_d;
  logic signed [W-1:0]       err_q, err_d;
  logic                      sx_neg_q, sx_neg_d;
  logic                      sy_neg_q, sy_neg_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      pix_valid_q, pix_valid_d;
  logic                      pix_last_q, pix_last_d;

  logic                      hs;
  logic signed [W-1:0]       e2;
  logic signed [W-1:0]       err_n;
  logic                      step_x;
  logic                      step_y;
  logic [COORD_W-1:0]        nx;
  logic [COORD_W-1:0]        ny;

  // |a-b| widened by two bits so the signed error term can never overflow
  function automatic logic signed [W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    logic signed [W-1:0] d;
    d = $signed({2'b00, a}) - $signed({2'b00, b});
    return (d < 0) ? -d : d;
  endfunction

  // Next-state, step decision and output computation for the whole engine
  always_comb begin
    state_d     = state_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    end_x_d     = end_x_q;
    end_y_d     = end_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    err_d       = err_q;
    sx_neg_d    = sx_neg_q;
    sy_neg_d    = sy_neg_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pix_valid_d = pix_valid_q;
    pix_last_d  = pix_last_q;

    hs     = pix_valid_q & bus.pix_ready;
    e2     = err_q <<< 1;
    step_x = (e2 >= -dy_q);
    step_y = (e2 <= dx_q);
    nx     = cur_x_q;
    ny     = cur_y_q;
    if (step_x) nx = sx_neg_q ? cur_x_q - COORD_W'(1) : cur_x_q + COORD_W'(1);
    if (step_y) ny = sy_neg_q ? cur_y_q - COORD_W'(1) : cur_y_q + COORD_W'(1);
    err_n = err_q;
    if (step_x) err_n = err_n - dy_q;
    if (step_y) err_n = err_n + dx_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // start point parks in the cursor registers until SETUP consumes it
          cur_x_d = bus.x0;
          cur_y_d = bus.y0;
          end_x_d = bus.x1;
          end_y_d = bus.y1;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (bus.abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          dx_d        = abs_diff(end_x_q, cur_x_q);
          dy_d        = abs_diff(end_y_q, cur_y_q);
          err_d       = abs_diff(end_x_q, cur_x_q) - abs_diff(end_y_q, cur_y_q);
          sx_neg_d    = (end_x_q < cur_x_q);
          sy_neg_d    = (end_y_q < cur_y_q);
          pix_valid_d = 1'b1;
          pix_last_d  = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
          state_d     = S_DRAW;
        end
      end
      S_DRAW: begin
        if (bus.abort) begin
          pix_valid_d = 1'b0;
          pix_last_d  = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else if (hs && pix_last_q) begin
          pix_valid_d = 1'b0;
          pix_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end else if (hs) begin
          cur_x_d    = nx;
          cur_y_d    = ny;
          err_d      = err_n;
          pix_last_d = (nx == end_x_q) && (ny == end_y_q);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d      = 1'b0;
        pix_valid_d = 1'b0;
        pix_last_d  = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything including the visible pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      end_x_q     <= '0;
      end_y_q     <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      sx_neg_q    <= 1'b0;
      sy_neg_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      end_x_q     <= end_x_d;
      end_y_q     <= end_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      err_q       <= err_d;
      sx_neg_q    <= sx_neg_d;
      sy_neg_q    <= sy_neg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_x     = cur_x_q;
  assign bus.pix_y     = cur_y_q;
  assign bus.pix_last  = pix_last_q;
endmodule

// File: tb/tb_bresenham_line_engine.sv
// Bench for bresenham_line_engine: directed table, hand-written corner sequences and
// randomized lines compared with an integer Bresenham reference model.
module tb_bresenham_line_engine;
  localparam int CW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bresenham_line_engine_if #(.COORD_W(CW)) bus ();

  bresenham_line_engine #(.COORD_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int x0; int y0; int x1; int y1;
    int n;  int lx; int ly; int mode;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int gx[$], gy[$], gl[$];
  int mx[$], my[$];
  int exp_x[$], exp_y[$];

  task automatic check(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the textbook integer Bresenham walk, producing the full pixel list
  task automatic model(input int ax, input int ay, input int bx, input int by);
    int dx, dy, sx, sy, err, e2, x, y;
    mx.delete(); my.delete();
    dx = (bx > ax) ? bx - ax : ax - bx;
    dy = (by > ay) ? by - ay : ay - by;
    sx = (bx >= ax) ? 1 : -1;
    sy = (by >= ay) ? 1 : -1;
    err = dx - dy;
    x = ax; y = ay;
    for (int k = 0; k < 4096; k++) begin
      mx.push_back(x); my.push_back(y);
      if (x == bx && y == by) break;
      e2 = 2 * err;
      if (e2 >= -dy) begin err -= dy; x += sx; end
      if (e2 <= dx)  begin err += dx; y += sy; end
    end
  endtask

  // mode bits: 1 random ready, 2 ready low 3 cycles after 2nd beat,
  // 4 pulse start mid-line, 8 abort asserted together with start
  task automatic run_line(input int ax, input int ay, input int bx, input int by,
                          input int mode);
    bit fin, stalled, seen, r;
    int px, py, pl, hs, stall_cnt, first_cyc, last_cyc;
    gx.delete(); gy.delete(); gl.delete();
    fin = 0; stalled = 0; seen = 0; hs = 0; stall_cnt = 0;
    px = 0; py = 0; pl = 0; first_cyc = 0; last_cyc = 0;
    bus.x0 = ax[CW-1:0]; bus.y0 = ay[CW-1:0];
    bus.x1 = bx[CW-1:0]; bus.y1 = by[CW-1:0];
    bus.start = 1'b1;
    bus.abort = ((mode & 8) != 0);
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.x0 = CW'($urandom); bus.y0 = CW'($urandom);
    bus.x1 = CW'($urandom); bus.y1 = CW'($urandom);
    check("setup_busy", bus.busy, 1);
    check("setup_valid", bus.pix_valid, 0);
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      tick();
      if (cyc == 0) check("first_valid_latency", bus.pix_valid, 1);
      if (!bus.pix_valid) begin
        check("valid_during_draw", 0, 1);
        break;
      end
      if (stalled) begin
        check("hold_x", bus.pix_x, px);
        check("hold_y", bus.pix_y, py);
        check("hold_last", bus.pix_last, pl);
      end
      if ((mode & 1) != 0) r = 1'($urandom_range(1));
      else if ((mode & 2) != 0) r = !(hs == 2 && stall_cnt < 3);
      else r = 1'b1;
      if (!r) stall_cnt++;
      bus.start = ((mode & 4) != 0) && (cyc == 10);
      bus.pix_ready = r;
      px = bus.pix_x; py = bus.pix_y; pl = bus.pix_last;
      stalled = !r;
      if (r) begin
        gx.push_back(px); gy.push_back(py); gl.push_back(pl);
        hs++;
        if (!seen) first_cyc = cyc;
        seen = 1;
        last_cyc = cyc;
        if (pl != 0) fin = 1;
      end
    end
    bus.start = 1'b0;
    if (!fin) check("line_finished", 0, 1);
    else begin
      tick();
      check("done_pulse", bus.done, 1);
      check("done_valid_low", bus.pix_valid, 0);
      check("done_busy", bus.busy, 1);
      tick();
      check("done_cleared", bus.done, 0);
      check("idle_busy", bus.busy, 0);
      if ((mode & 3) == 0) check("back_to_back", last_cyc - first_cyc, gx.size() - 1);
    end
    bus.pix_ready = 1'b1;
  endtask

  task automatic cmp_model(input string nm, input int ax, input int ay, input int bx,
                           input int by);
    int n;
    model(ax, ay, bx, by);
    check({nm, "_count"}, gx.size(), mx.size());
    n = (gx.size() < mx.size()) ? gx.size() : mx.size();
    for (int i = 0; i < n; i++) begin
      check({nm, "_x"}, gx[i], mx[i]);
      check({nm, "_y"}, gy[i], my[i]);
      check({nm, "_last"}, gl[i], (i == mx.size() - 1) ? 1 : 0);
    end
  endtask

  task automatic cmp_exp(input string nm);
    int n;
    check({nm, "_count"}, gx.size(), exp_x.size());
    n = (gx.size() < exp_x.size()) ? gx.size() : exp_x.size();
    for (int i = 0; i < n; i++) begin
      check({nm, "_x"}, gx[i], exp_x[i]);
      check({nm, "_y"}, gy[i], exp_y[i]);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_busy"}, bus.busy, 0);
    check({nm, "_done"}, bus.done, 0);
    check({nm, "_valid"}, bus.pix_valid, 0);
    check({nm, "_last"}, bus.pix_last, 0);
    check({nm, "_x"}, bus.pix_x, 0);
    check({nm, "_y"}, bus.pix_y, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[8];
    int ax, ay, bx, by, last_x, last_y;
    tv[0] = '{0, 0, 4, 0, 5, 4, 0, 0};
    tv[1] = '{0, 0, 3, 1, 4, 3, 1, 0};
    tv[2] = '{3, 1, 0, 0, 4, 0, 0, 0};
    tv[3] = '{5, 5, 5, 5, 1, 5, 5, 0};
    tv[4] = '{0, 0, 2, 6, 7, 2, 6, 2};
    tv[5] = '{1023, 0, 0, 1023, 1024, 0, 1023, 4};
    tv[6] = '{10, 20, 2, 17, 9, 2, 17, 8};
    tv[7] = '{7, 30, 9, 0, 31, 9, 0, 1};

    bus.start = 1'b0; bus.abort = 1'b0; bus.pix_ready = 1'b1;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("post_reset");

    // directed pixel sequences
    run_line(0, 0, 4, 0, 0);
    exp_x = '{0, 1, 2, 3, 4}; exp_y = '{0, 0, 0, 0, 0};
    cmp_exp("horiz");
    run_line(0, 0, 3, 1, 0);
    exp_x = '{0, 1, 2, 3}; exp_y = '{0, 0, 1, 1};
    cmp_exp("shallow_fwd");
    run_line(3, 1, 0, 0, 0);
    exp_x = '{3, 2, 1, 0}; exp_y = '{1, 1, 0, 0};
    cmp_exp("shallow_rev");

    // table of vectors
    for (int i = 0; i < 8; i++) begin
      run_line(tv[i].x0, tv[i].y0, tv[i].x1, tv[i].y1, tv[i].mode);
      check("tbl_count", gx.size(), tv[i].n);
      last_x = (gx.size() > 0) ? gx[gx.size() - 1] : -1;
      last_y = (gy.size() > 0) ? gy[gy.size() - 1] : -1;
      check("tbl_end_x", last_x, tv[i].lx);
      check("tbl_end_y", last_y, tv[i].ly);
      cmp_model("tbl", tv[i].x0, tv[i].y0, tv[i].x1, tv[i].y1);
    end

    // abort after two handshakes
    bus.x0 = 0; bus.y0 = 0; bus.x1 = 9; bus.y1 = 9;
    bus.start = 1'b1; bus.pix_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("abort_p0_x", bus.pix_x, 0);
    tick();
    check("abort_p1_x", bus.pix_x, 1);
    check("abort_p1_y", bus.pix_y, 1);
    tick();
    check("abort_p2_valid", bus.pix_valid, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_valid", bus.pix_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    tick();
    check("abort_no_done", bus.done, 0);
    check("abort_idle", bus.busy, 0);
    run_line(1, 1, 1, 3, 0);
    exp_x = '{1, 1, 1}; exp_y = '{1, 2, 3};
    cmp_exp("after_abort");

    // reset mid-line
    bus.x0 = 0; bus.y0 = 0; bus.x1 = 9; bus.y1 = 9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_valid", bus.pix_valid, 1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    tick();
    rst = 1'b0;
    tick();
    check("rst_release_busy", bus.busy, 0);
    run_line(4, 4, 7, 5, 8);
    cmp_model("after_rst", 4, 4, 7, 5);

    // randomized lines
    for (int i = 0; i < 24; i++) begin
      ax = $urandom_range(1023); ay = $urandom_range(1023);
      bx = ax + $urandom_range(80) - 40; by = ay + $urandom_range(80) - 40;
      if (bx < 0) bx = 0;
      if (bx > 1023) bx = 1023;
      if (by < 0) by = 0;
      if (by > 1023) by = 1023;
      run_line(ax, ay, bx, by, $urandom_range(1));
      cmp_model("rand", ax, ay, bx, by);
    end
    for (int i = 0; i < 2; i++) begin
      ax = $urandom_range(1023); ay = $urandom_range(1023);
      bx = $urandom_range(1023); by = $urandom_range(1023);
      run_line(ax, ay, bx, by, 1);
      cmp_model("rand_long", ax, ay, bx, by);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
